pipe_stage_skid_reg: RTL and testbench

PIPE_STAGE_SKID_REG -- requirements
Module: pipe_stage_skid_reg

---
 rtl/pipe_reg_pkg.sv | 14 +
 rtl/pipe_stage_skid_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_skid_reg.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared definitions for the pipeline skid register: state encoding and
// default payload/counter widths.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_CNT_W  = 16;

endpackage

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline register with an optional second (skid) entry that
// lets IN_READY be registered, plus a saturating stalled-cycle counter.
module pipe_stage_skid_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned              DATA_W    = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0]        RESET_VAL = '0,
    parameter bit                       SKID_EN   = 1'b1,
    parameter int unsigned              CNT_W     = DEFAULT_CNT_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CNT_W-1:0]  STALL_CNT
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic              in_ready;
    logic              accept;
    logic              send;

    assign OUT_VALID = (state_q != ST_EMPTY);
    assign OUT_DATA  = main_q;
    assign STALL_CNT = stall_cnt_q;

    // Skid mode decouples IN_READY from OUT_READY; stall mode passes it through.
    assign in_ready = SKID_EN ? in_ready_q : (OUT_READY || !OUT_VALID);
    assign IN_READY = in_ready;

    assign accept = IN_VALID && in_ready;
    assign send   = OUT_VALID && OUT_READY;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (FLUSH) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        main_d  = IN_DATA;
                    end
                end
                ST_FULL: begin
                    if (accept && send) begin
                        main_d = IN_DATA;
                    end else if (accept && SKID_EN) begin
                        state_d = ST_SKID;
                        skid_d  = IN_DATA;
                    end else if (send) begin
                        // Main is reloaded with the bubble value so OUT_DATA stays clean while idle.
                        state_d = ST_EMPTY;
                        main_d  = RESET_VAL;
                    end
                end
                ST_SKID: begin
                    if (send) begin
                        state_d = ST_FULL;
                        main_d  = skid_q;
                        skid_d  = RESET_VAL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end

        in_ready_d = (state_d != ST_SKID);

        stall_cnt_d = stall_cnt_q;
        if (OUT_VALID && !OUT_READY && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed bench for pipe_stage_skid_reg: skid mode, narrow saturating
// counter, and single-entry stall mode, each on its own instance.
module tb_pipe_stage_skid_reg;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Instance A: skid mode, non-zero bubble value
    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [15:0] a_stall_cnt;

    pipe_stage_skid_reg #(.DATA_W(32), .RESET_VAL(32'h55), .SKID_EN(1'b1), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET), .FLUSH(a_flush),
        .IN_VALID(a_in_valid), .IN_READY(a_in_ready), .IN_DATA(a_in_data),
        .OUT_VALID(a_out_valid), .OUT_READY(a_out_ready), .OUT_DATA(a_out_data),
        .STALL_CNT(a_stall_cnt)
    );

    // Instance S: 4-bit stall counter
    logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_data, s_out_data;
    logic [3:0]  s_stall_cnt;

    pipe_stage_skid_reg #(.DATA_W(32), .RESET_VAL(32'h0), .SKID_EN(1'b1), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RESET(RESET), .FLUSH(1'b0),
        .IN_VALID(s_in_valid), .IN_READY(s_in_ready), .IN_DATA(s_in_data),
        .OUT_VALID(s_out_valid), .OUT_READY(s_out_ready), .OUT_DATA(s_out_data),
        .STALL_CNT(s_stall_cnt)
    );

    // Instance N: single-entry stall mode
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_data, n_out_data;
    logic [15:0] n_stall_cnt;

    pipe_stage_skid_reg #(.DATA_W(32), .RESET_VAL(32'h0), .SKID_EN(1'b0), .CNT_W(16)) dut_ns (
        .CLK(CLK), .RESET(RESET), .FLUSH(1'b0),
        .IN_VALID(n_in_valid), .IN_READY(n_in_ready), .IN_DATA(n_in_data),
        .OUT_VALID(n_out_valid), .OUT_READY(n_out_ready), .OUT_DATA(n_out_data),
        .STALL_CNT(n_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hDEAD; a_out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;

        // Reset held two cycles with a pending input
        tick(); tick();
        check("rst_out_valid", {31'b0, a_out_valid}, 32'h0);
        check("rst_out_data", a_out_data, 32'h55);
        check("rst_stall_cnt", {16'b0, a_stall_cnt}, 32'h0);
        check("rst_in_ready", {31'b0, a_in_ready}, 32'h1);

        RESET = 1'b0; a_in_valid = 1'b0;
        tick();

        // Back-to-back stream
        a_out_ready = 1'b1; a_in_valid = 1'b1;
        a_in_data = 32'h1; tick(); check("stream_1", a_out_data, 32'h1);
        a_in_data = 32'h2; tick(); check("stream_2", a_out_data, 32'h2);
        a_in_data = 32'h3; tick(); check("stream_3", a_out_data, 32'h3);
        check("stream_valid", {31'b0, a_out_valid}, 32'h1);
        a_in_valid = 1'b0; tick();
        check("stream_drain_valid", {31'b0, a_out_valid}, 32'h0);
        check("stream_drain_data", a_out_data, 32'h55);
        check("stream_no_stall", {16'b0, a_stall_cnt}, 32'h0);

        // Skid: FULL with 0xA, stalled accept of 0xB
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'hA; tick();
        check("skid_full_data", a_out_data, 32'hA);
        check("skid_full_ready", {31'b0, a_in_ready}, 32'h1);
        a_in_data = 32'hB; tick();
        check("skid_hold_data", a_out_data, 32'hA);
        check("skid_in_ready", {31'b0, a_in_ready}, 32'h0);
        check("skid_stall_1", {16'b0, a_stall_cnt}, 32'h1);
        a_in_valid = 1'b0; a_out_ready = 1'b1; tick();
        check("skid_second", a_out_data, 32'hB);
        check("skid_ready_back", {31'b0, a_in_ready}, 32'h1);
        tick();
        check("skid_empty", {31'b0, a_out_valid}, 32'h0);

        // Flush from SKID with a simultaneous accept attempt
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_data = 32'h11; tick();
        a_in_data = 32'h22; tick();
        check("flush_pre_skid", {31'b0, a_in_ready}, 32'h0);
        a_flush = 1'b1; a_in_data = 32'hC; tick();
        check("flush_valid", {31'b0, a_out_valid}, 32'h0);
        check("flush_data", a_out_data, 32'h55);
        check("flush_in_ready", {31'b0, a_in_ready}, 32'h1);
        check("flush_keeps_cnt", {16'b0, a_stall_cnt}, 32'h3);
        a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1; tick();
        check("flush_no_c", {31'b0, a_out_valid}, 32'h0);
        a_in_valid = 1'b1; a_in_data = 32'h33; tick();
        check("post_flush_data", a_out_data, 32'h33);

        // Reset wins in the middle of a SKID transfer
        a_out_ready = 1'b0; a_in_data = 32'h44; tick();
        check("rst2_pre_skid", {31'b0, a_in_ready}, 32'h0);
        RESET = 1'b1; a_out_ready = 1'b1; tick();
        check("rst2_valid", {31'b0, a_out_valid}, 32'h0);
        check("rst2_data", a_out_data, 32'h55);
        check("rst2_cnt", {16'b0, a_stall_cnt}, 32'h0);
        check("rst2_in_ready", {31'b0, a_in_ready}, 32'h1);
        RESET = 1'b0; a_in_valid = 1'b0; tick();

        // Saturation on a 4-bit counter
        s_in_valid = 1'b1; s_in_data = 32'h9; tick();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) check("sat_14", {28'b0, s_stall_cnt}, 32'd14);
            if (i == 15) check("sat_15", {28'b0, s_stall_cnt}, 32'd15);
        end
        check("sat_hold", {28'b0, s_stall_cnt}, 32'd15);
        check("sat_data", s_out_data, 32'h9);

        // Single-entry stall mode
        n_in_valid = 1'b1; n_in_data = 32'h5; #1;
        check("ns_empty_ready", {31'b0, n_in_ready}, 32'h1);
        tick();
        check("ns_full_ready", {31'b0, n_in_ready}, 32'h0);
        n_in_data = 32'h6; tick();
        check("ns_blocked_data", n_out_data, 32'h5);
        n_out_ready = 1'b1; n_in_data = 32'h7; #1;
        check("ns_comb_ready", {31'b0, n_in_ready}, 32'h1);
        tick();
        check("ns_next_data", n_out_data, 32'h7);
        n_in_valid = 1'b0; tick();
        check("ns_drain_valid", {31'b0, n_out_valid}, 32'h0);
        check("ns_drain_data", n_out_data, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
